alu_rol_seq: RTL
================

# alu_rol_seq

Multi-cycle rotate sequencer for the 5-bit ALU. It accepts a 5-bit operand and a full 5-bit rotate amount (0..31), reduces the amount modulo 5, then drives the shared 5-bit rotate-left unit one pass at a time (≤ STEP_MAX positions per pass) until the rotation is complete. It sits between the ALU FSM's opcode decode and the rotate datapath, and reports completion with a start/busy/done handshake.

## Interface
- STEP_MAX, 4, maximum rotate amount per pass through the rotate unit; legal 1..4.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only when ready=1.
- a_in  in  5  operand, captured on an accepted start.
- amt_in  in  5  rotate-left amount 0..31, captured on an accepted start.
- ready  out  1  high in IDLE and DONE; start is accepted.
- busy  out  1  high in REDUCE and ROTATE.
- done  out  1  one-cycle pulse; result is valid.
- result  out  5  rotated operand; held until the next accepted start.
- pass_cnt  out  3  number of rotate-unit passes used by the last operation.

## Operation
- The block instantiates the 5-bit rotate-left unit internally. Its operand is the working register `data`. Its 3-bit amount is `step`, where step = min(rem, STEP_MAX).
- State IDLE: ready=1. On start, it loads data←a_in, rem←amt_in and pass_cnt←0, then goes to REDUCE.
- State REDUCE:
  - If rem ≥ 5, it sets rem←rem−5 and stays in REDUCE.
  - Else if rem = 0, it goes to DONE.
  - Else it goes to ROTATE.
- State ROTATE, each cycle:
  - data←rol(data, step), rem←rem−step, pass_cnt←pass_cnt+1.
  - If the new rem = 0, it goes to DONE; otherwise it stays in ROTATE.
- State DONE:
  - done=1 and result=data.
  - With start, it loads a new operation and goes to REDUCE (back-to-back operation).
  - Without start, it goes to IDLE.
- start while busy=1 is ignored: no capture, and in-flight state is unchanged.
- The result is identical for every legal STEP_MAX. STEP_MAX changes only latency and pass_cnt.
- pass_cnt saturates at 7. It cannot overflow for legal parameters, since the maximum is 4 passes.
- rem is 5 bits and never goes negative: subtraction happens only when rem ≥ 5 or rem ≥ step.

## Timing
- Reset: state=IDLE, data=0, rem=0, result=0, done=0, busy=0, ready=1, pass_cnt=0.
- A reset asserted mid-operation aborts it on that edge. No done pulse is produced, and all outputs return to their reset values.
- Let r = amt_in mod 5. Latency is counted from the start-accepting edge to the edge that leaves done high:
  - Without the macro: L = 1 + floor(amt_in/5) + ceil(r/STEP_MAX).
  - With the macro: L = 1 + ceil(r/STEP_MAX).
- done stays high for exactly 1 cycle. result changes only on the edge entering DONE and is stable otherwise.
- Back-to-back: a start accepted in DONE puts busy=1 on the next cycle with no IDLE gap.

## Configuration
- ALU_ROL_SEQ_FAST_MOD_EN, defined:
  - REDUCE lasts exactly one cycle and computes rem←amt mod 5 combinationally.
  - It then goes to DONE if the residue is 0, otherwise to ROTATE.
- ALU_ROL_SEQ_FAST_MOD_EN, undefined:
  - Iterative subtract-5 reduction as described above, at 1 cycle per subtraction.
  - Smaller area, longer latency.
- Functional results are identical in both builds.

## Test plan
- Basic rotate: a_in=5'b10011, amt_in=13, STEP_MAX=4 → result=5'b11100, pass_cnt=1, done 4 cycles after start (2 cycles with ALU_ROL_SEQ_FAST_MOD_EN).
- Zero amount: a_in=5'b10110, amt_in=0 → result=5'b10110, pass_cnt=0, done after 1 cycle.
- Multiples of 5 and wrap-around:
  - a_in=5'b00001, amt_in=31 → result=5'b00010, done after 8 cycles (2 with the macro).
  - amt_in=30 → result=a_in, pass_cnt=0.
- Minimum step: STEP_MAX=1, a_in=5'b10000, amt_in=4 → result=5'b01000, pass_cnt=4, done after 5 cycles. The same stimulus with STEP_MAX=4 gives the same result with pass_cnt=1.
- Handshake:
  - A start pulsed while busy with different operands is ignored, and the original result is produced.
  - A start in the DONE cycle launches the next operation with no IDLE cycle.
- Reset mid-operation: rst_n=0 during ROTATE → no done pulse; result=0, ready=1 on the next cycle. A fresh start then completes correctly.

Source files
------------

// File: rtl/alu_rol_seq.sv
// Multi-cycle rotate-left sequencer driving a shared 5-bit rotate unit.
// Define ALU_ROL_SEQ_FAST_MOD_EN to reduce the amount modulo 5 in a single cycle.

module alu_rol5 (
   input  logic [4:0] i_data,
   input  logic [2:0] i_amt,
   output logic [4:0] o_data
);

   always_comb begin
      o_data = i_data;
      case (i_amt)
         3'd1:    o_data = {i_data[3:0], i_data[4]};
         3'd2:    o_data = {i_data[2:0], i_data[4:3]};
         3'd3:    o_data = {i_data[1:0], i_data[4:2]};
         3'd4:    o_data = {i_data[0],   i_data[4:1]};
         default: o_data = i_data;
      endcase
   end

endmodule

module alu_rol_seq #(
   parameter int STEP_MAX = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [4:0] a_in,
   input  logic [4:0] amt_in,
   output logic       ready,
   output logic       busy,
   output logic       done,
   output logic [4:0] result,
   output logic [2:0] pass_cnt
);

   typedef enum logic [1:0] {IDLE, REDUCE, ROTATE, DONE} state_t;

   localparam logic [4:0] STEP_LIM = 5'(STEP_MAX);

   state_t     r_state;
   state_t     w_nextState;
   logic [4:0] r_data;
   logic [4:0] r_rem;
   logic [4:0] r_result;
   logic [2:0] r_passCnt;
   logic [2:0] w_step;
   logic [4:0] w_rolOut;
   logic [4:0] w_remAfter;
   logic       w_accept;

   // Once reduced, rem is below 5, so the low three bits carry the whole step.
   assign w_step     = (r_rem < STEP_LIM) ? r_rem[2:0] : STEP_LIM[2:0];
   assign w_remAfter = r_rem - {2'b00, w_step};
   assign w_accept   = ready & start;
   assign result     = r_result;
   assign pass_cnt   = r_passCnt;

`ifdef ALU_ROL_SEQ_FAST_MOD_EN
   logic [4:0] w_remMod;
   assign w_remMod = r_rem % 5'd5;
`endif

   alu_rol5 u_rol (
      .i_data (r_data),
      .i_amt  (w_step),
      .o_data (w_rolOut)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      ready       = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         IDLE: begin
            ready = 1'b1;
            if (start) w_nextState = REDUCE;
         end
         REDUCE: begin
            busy = 1'b1;
`ifdef ALU_ROL_SEQ_FAST_MOD_EN
            w_nextState = (w_remMod == 5'd0) ? DONE : ROTATE;
`else
            if (r_rem >= 5'd5)      w_nextState = REDUCE;
            else if (r_rem == 5'd0) w_nextState = DONE;
            else                    w_nextState = ROTATE;
`endif
         end
         ROTATE: begin
            busy = 1'b1;
            if (w_remAfter == 5'd0) w_nextState = DONE;
         end
         DONE: begin
            ready       = 1'b1;
            done        = 1'b1;
            w_nextState = start ? REDUCE : IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // result is written only on the edge that enters DONE, so it holds between operations.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_data    <= 5'd0;
         r_rem     <= 5'd0;
         r_result  <= 5'd0;
         r_passCnt <= 3'd0;
      end else if (w_accept) begin
         r_data    <= a_in;
         r_rem     <= amt_in;
         r_passCnt <= 3'd0;
      end else if (r_state == REDUCE) begin
`ifdef ALU_ROL_SEQ_FAST_MOD_EN
         r_rem <= w_remMod;
         if (w_remMod == 5'd0) r_result <= r_data;
`else
         if (r_rem >= 5'd5)      r_rem    <= r_rem - 5'd5;
         else if (r_rem == 5'd0) r_result <= r_data;
`endif
      end else if (r_state == ROTATE) begin
         r_data <= w_rolOut;
         r_rem  <= w_remAfter;
         if (r_passCnt != 3'd7)  r_passCnt <= r_passCnt + 3'd1;
         if (w_remAfter == 5'd0) r_result  <= w_rolOut;
      end
   end

endmodule
